// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract: one full adder and a carry flop, LSB first, WIDTH cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic x, y, s, c_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // y is the operand-select mux output: b or ~b per the latched sub flag
        x     = a_sh_q[0];
        y     = b_sh_q[0] ^ sub_q;
        s     = x ^ y ^ carry_q;
        c_nxt = (x & y) | (x & carry_q) | (y & carry_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    sub_d   = sub_i;
                    carry_d = sub_i;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = {s, acc_q[WIDTH-1:1]};
                carry_d = c_nxt;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = {s, acc_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
                    ovf_d   = (x == y) && (s != x);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=8): transaction-level model plus literal result checks.
module tb_serial_addsub_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    bit chk_en = 1'b0;

    serial_addsub_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .sub_i   (sub),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf_o   (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    // Transaction-level model: result computed arithmetically, published WIDTH edges after accept
    logic         m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
    logic [W-1:0] m_sum = '0;
    logic [W-1:0] p_sum;
    logic         p_cout, p_ovf;
    int           m_left = 0;

    always @(posedge clk) begin
        logic [W:0]   t;
        logic [W-1:0] yv;
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_sum <= '0; m_cout <= 0; m_ovf <= 0; m_left <= 0;
            chk_en <= 1'b1;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    m_sum  <= p_sum;
                    m_cout <= p_cout;
`ifdef SERIAL_ADD_OVF_EN
                    m_ovf  <= p_ovf;
`endif
                end
                m_left <= m_left - 1;
            end else if (start) begin
                yv = sub ? ~b : b;
                t = {1'b0, a} + {1'b0, yv} + {{W{1'b0}}, sub};
                p_sum  <= t[W-1:0];
                p_cout <= t[W];
                p_ovf  <= (a[W-1] == yv[W-1]) && (t[W-1] != a[W-1]);
                m_busy <= 1;
                m_left <= W;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("busy", {7'b0, busy}, {7'b0, m_busy});
            chk("done", {7'b0, done}, {7'b0, m_done});
            chk("sum",  sum, m_sum);
            chk("cout", {7'b0, cout}, {7'b0, m_cout});
            chk("ovf",  {7'b0, ovf},  {7'b0, m_ovf});
        end
    end

    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb);
        @(posedge clk); #1;
        start = s; a = av; b = bv; sub = sb;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s_timeout: done not seen, got %b expected 1", name, done);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sb, input logic [W-1:0] es, input logic ec, input logic eo);
        drive(1'b1, av, bv, sb);
        drive(1'b0, '0, '0, 1'b0);
        wait_done(name);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, {7'b0, cout}, {7'b0, ec});
`ifdef SERIAL_ADD_OVF_EN
        chk({name, "_ovf"}, {7'b0, ovf}, {7'b0, eo});
`endif
    endtask

    initial begin
        int d1;
        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_sum", sum, 8'h00);

        // 2. add
        run_op("add1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_op("add2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        // 3. sub
        run_op("sub1", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
        run_op("sub2", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);

        // 4. start held during RUN with changing operands, then back-to-back from DONE
        drive(1'b1, 8'h22, 8'h11, 1'b0);
        drive(1'b1, 8'h44, 8'h55, 1'b0);
        wait_done("b2b1");
        chk("b2b1_sum", sum, 8'h33);
        d1 = cyc;
        @(posedge clk); #1 start = 0;
        wait_done("b2b2");
        chk("b2b2_sum", sum, 8'h99);
        chk("b2b_spacing", 8'(cyc - d1), 8'd9);

        // 5. reset mid-RUN
        drive(1'b1, 8'h12, 8'h34, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_busy", {7'b0, busy}, 8'h00);
        chk("midrst_sum", sum, 8'h00);
        repeat (12) @(negedge clk);
        chk("midrst_nodone", {7'b0, done}, 8'h00);
        run_op("after_rst", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);

        // 6. signed overflow boundaries
        run_op("ovf_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("ovf_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
